// File: rtl/rgb_lookup_arbiter_pkg.sv
// Shared definitions for the colour-to-RGB lookup arbiter: FSM states, grant
// identifiers and the default contents of the colour memory.
package rgb_lookup_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_e;

   // Default colour memory image, indexed by 3-bit colour code.
   localparam logic [23:0] DEFAULT_RGB [8] = '{
      24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
      24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
   };

   function automatic logic [23:0] default_rgb(input logic [2:0] colour);
      return DEFAULT_RGB[colour];
   endfunction

endpackage

// File: rtl/rgb_lookup_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to whichever requester was not granted last.
module rr_arb2
   import rgb_lookup_arbiter_pkg::*;
(
   input  logic   req_a_i,
   input  logic   req_b_i,
   input  grant_e last_grant_i,
   output logic   gnt_a_o,
   output logic   gnt_b_o
);

   always_comb begin
      gnt_a_o = req_a_i && (!req_b_i || (last_grant_i == GRANT_B));
      gnt_b_o = req_b_i && (!req_a_i || (last_grant_i == GRANT_A));
   end

endmodule

// File: rtl/rgb_lookup_arbiter.sv
// Shares a single-port read-only colour memory between requesters A and B:
// round-robin grant, one-cycle memory enable, latency wait, per-requester response.
module rgb_lookup_arbiter
   import rgb_lookup_arbiter_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        req_valid_a,
   input  logic [2:0]  colour_a,
   output logic        req_ready_a,
   output logic        resp_valid_a,
   output logic [23:0] rgb_a,
   input  logic        req_valid_b,
   input  logic [2:0]  colour_b,
   output logic        req_ready_b,
   output logic        resp_valid_b,
   output logic [23:0] rgb_b,
   output logic        rom_en,
   output logic [2:0]  rom_addr,
   input  logic [23:0] rom_data
);

   localparam int unsigned CNT_W = 2;

   state_e             state_q, state_d;
   grant_e             grant_q, last_grant_q, grant_sel;
   logic [2:0]         rom_addr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [23:0]        rgb_a_q, rgb_b_q;
   logic               gnt_a, gnt_b;

   rr_arb2 u_rr_arb2 (
      .req_a_i      (enable && req_valid_a),
      .req_b_i      (enable && req_valid_b),
      .last_grant_i (last_grant_q),
      .gnt_a_o      (gnt_a),
      .gnt_b_o      (gnt_b)
   );

   assign grant_sel = gnt_a ? GRANT_A : GRANT_B;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (gnt_a || gnt_b) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (cnt_q == '0) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Data is captured at the end of the last WAIT cycle so rgb_x first shows the
   // new value in the RESP cycle, alongside its strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q      <= GRANT_A;
         last_grant_q <= GRANT_B;
         rom_addr_q   <= '0;
         cnt_q        <= '0;
         rgb_a_q      <= '0;
         rgb_b_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_a || gnt_b) begin
                  grant_q      <= grant_sel;
                  last_grant_q <= grant_sel;
                  rom_addr_q   <= gnt_a ? colour_a : colour_b;
               end
            end
            ST_ISSUE: cnt_q <= CNT_W'(LATENCY - 1);
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  if (grant_q == GRANT_A) rgb_a_q <= rom_data;
                  else                    rgb_b_q <= rom_data;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Ready is qualified by rst_n so it stays low while reset is held.
   always_comb begin
      req_ready_a  = rst_n && (state_q == ST_IDLE) && gnt_a;
      req_ready_b  = rst_n && (state_q == ST_IDLE) && gnt_b;
      resp_valid_a = (state_q == ST_RESP) && (grant_q == GRANT_A);
      resp_valid_b = (state_q == ST_RESP) && (grant_q == GRANT_B);
      rom_en       = (state_q == ST_ISSUE);
      rom_addr     = rom_addr_q;
      rgb_a        = rgb_a_q;
      rgb_b        = rgb_b_q;
   end

endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
// Directed bench for rgb_lookup_arbiter: LATENCY=1 and LATENCY=3 instances, each
// fed by a behavioural colour memory; expected values are written out per cycle.
module tb_rgb_lookup_arbiter;
   import rgb_lookup_arbiter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   int          n_checks = 0;
   int          n_fail   = 0;

   // LATENCY=1 instance
   logic        en, va, vb, rdy_a, rdy_b, rv_a, rv_b, rom_en;
   logic [2:0]  ca, cb, rom_addr;
   logic [23:0] rgb_a, rgb_b, rom_data;

   // LATENCY=3 instance
   logic        en3, va3, vb3, rdy_a3, rdy_b3, rv_a3, rv_b3, rom_en3;
   logic [2:0]  ca3, cb3, rom_addr3;
   logic [23:0] rgb_a3, rgb_b3, rom_data3;
   logic [23:0] rom3_s0, rom3_s1, rom3_s2;

   rgb_lookup_arbiter #(.LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(en),
      .req_valid_a(va), .colour_a(ca), .req_ready_a(rdy_a), .resp_valid_a(rv_a), .rgb_a(rgb_a),
      .req_valid_b(vb), .colour_b(cb), .req_ready_b(rdy_b), .resp_valid_b(rv_b), .rgb_b(rgb_b),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   rgb_lookup_arbiter #(.LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .enable(en3),
      .req_valid_a(va3), .colour_a(ca3), .req_ready_a(rdy_a3), .resp_valid_a(rv_a3), .rgb_a(rgb_a3),
      .req_valid_b(vb3), .colour_b(cb3), .req_ready_b(rdy_b3), .resp_valid_b(rv_b3), .rgb_b(rgb_b3),
      .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3)
   );

   // Colour memories: data valid LATENCY edges after the edge that samples the address.
   initial rom_data = '0;
   always @(posedge clk) if (rom_en) rom_data <= default_rgb(rom_addr);

   initial begin rom3_s0 = '0; rom3_s1 = '0; rom3_s2 = '0; end
   always @(posedge clk) begin
      if (rom_en3) rom3_s0 <= default_rgb(rom_addr3);
      rom3_s1 <= rom3_s0;
      rom3_s2 <= rom3_s1;
   end
   assign rom_data3 = rom3_s2;

   task automatic clear_inputs();
      en = 1'b0; va = 1'b0; vb = 1'b0; ca = '0; cb = '0;
      en3 = 1'b0; va3 = 1'b0; vb3 = 1'b0; ca3 = '0; cb3 = '0;
   endtask

   task automatic pulse_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [4:0] ctl;
      clear_inputs();
      rst_n = 1'b0;
      en = 1'b1; va = 1'b1; vb = 1'b1; en3 = 1'b1; va3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         ctl = {rdy_a, rdy_b, rv_a, rv_b, rom_en};
         n_checks++;
         if (ctl !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl k=%0d: got %b, expected 00000", k, ctl);
         end
         n_checks++;
         if ({rom_addr, rgb_a, rgb_b} !== 51'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h a=%h b=%h, expected all 0", rom_addr, rgb_a, rgb_b);
         end
         n_checks++;
         if ({rdy_a3, rdy_b3, rv_a3, rv_b3, rom_en3, rgb_a3} !== 29'h0) begin
            n_fail++; $display("FAIL reset_lat3: got rdy=%b rom_en=%b rgb_a=%h, expected 0", rdy_a3, rom_en3, rgb_a3);
         end
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_a();
      logic [4:0] ctl, exp_ctl;
      logic [23:0] exp_a;
      pulse_reset();
      en = 1'b1; va = 1'b1; ca = 3'd4;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) va = 1'b0;
         #1;
         ctl     = {rdy_a, rdy_b, rv_a, rv_b, rom_en};
         exp_ctl = {k == 0, 1'b0, k == 3, 1'b0, k == 1};
         exp_a   = (k >= 3) ? 24'hFF0000 : 24'h000000;
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL single_a_ctl k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
         n_checks++;
         if ({rgb_a, rgb_b} !== {exp_a, 24'h000000}) begin
            n_fail++; $display("FAIL single_a_rgb k=%0d: got a=%h b=%h, expected a=%h b=000000", k, rgb_a, rgb_b, exp_a);
         end
         if (k == 1) begin
            n_checks++;
            if (rom_addr !== 3'd4) begin
               n_fail++; $display("FAIL single_a_addr: got %0d, expected 4", rom_addr);
            end
         end
      end
   endtask

   task automatic test_tie();
      logic [3:0] ctl, exp_ctl;
      pulse_reset();
      en = 1'b1; va = 1'b1; ca = 3'd1; vb = 1'b1; cb = 3'd2;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         ctl     = {rdy_a, rdy_b, rv_a, rv_b};
         exp_ctl = {(k % 8) == 0, (k % 8) == 4, (k % 8) == 3, (k % 8) == 7};
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL tie_ctl k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
         if (k == 3) begin
            n_checks++;
            if ({rgb_a, rgb_b} !== {24'h0000FF, 24'h000000}) begin
               n_fail++; $display("FAIL tie_first: got a=%h b=%h, expected a=0000FF b=000000", rgb_a, rgb_b);
            end
         end
         if (k == 7) begin
            n_checks++;
            if ({rgb_a, rgb_b} !== {24'h0000FF, 24'h00FF00}) begin
               n_fail++; $display("FAIL tie_second: got a=%h b=%h, expected a=0000FF b=00FF00", rgb_a, rgb_b);
            end
         end
      end
      @(negedge clk);
      va = 1'b0; vb = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0] ctl, exp_ctl;
      logic [23:0] exp_b;
      pulse_reset();
      en = 1'b1; vb = 1'b1; cb = 3'd7;
      exp_b = 24'h000000;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) cb = 3'd3;
         if (k == 5) vb = 1'b0;
         #1;
         ctl     = {rdy_a, rdy_b, rv_a, rv_b, rom_en};
         exp_ctl = {1'b0, k == 0 || k == 4, 1'b0, k == 3 || k == 7, k == 1 || k == 5};
         if (k == 3) exp_b = 24'hFFFFFF;
         if (k == 7) exp_b = 24'h00FFFF;
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL b2b_ctl k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
         n_checks++;
         if ({rgb_a, rgb_b} !== {24'h000000, exp_b}) begin
            n_fail++; $display("FAIL b2b_rgb k=%0d: got a=%h b=%h, expected a=000000 b=%h", k, rgb_a, rgb_b, exp_b);
         end
         if (k == 1 || k == 5) begin
            n_checks++;
            if (rom_addr !== ((k == 1) ? 3'd7 : 3'd3)) begin
               n_fail++; $display("FAIL b2b_addr k=%0d: got %0d, expected %0d", k, rom_addr, (k == 1) ? 7 : 3);
            end
         end
      end
   endtask

   task automatic test_enable();
      logic [4:0] ctl, exp_ctl;
      pulse_reset();
      en = 1'b0; va = 1'b1; vb = 1'b1; ca = 3'd5; cb = 3'd3;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         n_checks++;
         if ({rdy_a, rdy_b, rom_en} !== 3'b000) begin
            n_fail++; $display("FAIL enable_block k=%0d: got rdy=%b%b rom_en=%b, expected 000", k, rdy_a, rdy_b, rom_en);
         end
      end
      @(negedge clk);
      en = 1'b1; vb = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) begin en = 1'b0; vb = 1'b1; end
         #1;
         ctl     = {rdy_a, rdy_b, rv_a, rv_b, rom_en};
         exp_ctl = {k == 0, 1'b0, k == 3, 1'b0, k == 1};
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL enable_drop_ctl k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
         if (k == 3) begin
            n_checks++;
            if (rgb_a !== 24'hFF00FF) begin
               n_fail++; $display("FAIL enable_drop_rgb: got %h, expected FF00FF", rgb_a);
            end
         end
      end
      va = 1'b0; vb = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      logic [4:0] ctl, exp_ctl;
      pulse_reset();
      en = 1'b1; va = 1'b1; ca = 3'd4;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) va = 1'b0;
         if (k == 4) begin va = 1'b1; ca = 3'd2; end
         #1;
         ctl     = {rdy_a, rdy_b, rv_a, rv_b, rom_en};
         exp_ctl = {k == 0 || k == 4, 1'b0, k == 3, 1'b0, k == 1};
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL rst_wait_pre k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
      end
      n_checks++;
      if (rgb_a !== 24'hFF0000) begin
         n_fail++; $display("FAIL rst_wait_first_rgb: got %h, expected FF0000", rgb_a);
      end
      @(negedge clk); va = 1'b0; #1;
      n_checks++;
      if ({rom_en, rom_addr} !== {1'b1, 3'd2}) begin
         n_fail++; $display("FAIL rst_wait_issue: got en=%b addr=%0d, expected en=1 addr=2", rom_en, rom_addr);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rdy_a, rdy_b, rv_a, rv_b, rom_en, rom_addr, rgb_a, rgb_b} !== 56'h0) begin
         n_fail++; $display("FAIL rst_wait_async: got rv=%b%b en=%b addr=%0d a=%h b=%h, expected all 0",
                            rv_a, rv_b, rom_en, rom_addr, rgb_a, rgb_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         n_checks++;
         if ({rv_a, rv_b, rgb_a} !== 26'h0) begin
            n_fail++; $display("FAIL rst_wait_no_resp k=%0d: got rv=%b%b a=%h, expected 0", k, rv_a, rv_b, rgb_a);
         end
      end
      @(negedge clk);
      va = 1'b1; ca = 3'd6;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) va = 1'b0;
         #1;
         ctl     = {rdy_a, rdy_b, rv_a, rv_b, rom_en};
         exp_ctl = {k == 0, 1'b0, k == 3, 1'b0, k == 1};
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL rst_wait_post k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
      end
      n_checks++;
      if (rgb_a !== 24'hFFFF00) begin
         n_fail++; $display("FAIL rst_wait_post_rgb: got %h, expected FFFF00", rgb_a);
      end
   endtask

   task automatic test_latency3();
      logic [4:0] ctl, exp_ctl;
      logic [23:0] exp_a;
      pulse_reset();
      en3 = 1'b1; va3 = 1'b1; ca3 = 3'd5;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) ca3 = 3'd1;
         if (k == 7) va3 = 1'b0;
         #1;
         ctl     = {rdy_a3, rdy_b3, rv_a3, rv_b3, rom_en3};
         exp_ctl = {k == 0 || k == 6, 1'b0, k == 5, 1'b0, k == 1 || k == 7};
         exp_a   = (k >= 5) ? 24'hFF00FF : 24'h000000;
         n_checks++;
         if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL lat3_ctl k=%0d: got %b, expected %b", k, ctl, exp_ctl);
         end
         n_checks++;
         if ({rgb_a3, rgb_b3} !== {exp_a, 24'h000000}) begin
            n_fail++; $display("FAIL lat3_rgb k=%0d: got a=%h b=%h, expected a=%h b=000000", k, rgb_a3, rgb_b3, exp_a);
         end
         if (k == 1 || k == 7) begin
            n_checks++;
            if (rom_addr3 !== ((k == 1) ? 3'd5 : 3'd1)) begin
               n_fail++; $display("FAIL lat3_addr k=%0d: got %0d, expected %0d", k, rom_addr3, (k == 1) ? 5 : 1);
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_a();
      test_tie();
      test_back_to_back();
      test_enable();
      test_reset_in_wait();
      test_latency3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
